// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver driven by an external 16x-baud square wave. The wave and the
// serial line are synchronized into the clk domain. Rising edges of the wave act
// as the oversampling enable, and each bit is sampled at its middle.
`timescale 1ns/1ps

module uart_rx_os16 #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 os_clk,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int unsigned TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TickMid  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TickLast = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BitLast  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  logic [1:0]           os_sync_q;
  logic [1:0]           rx_sync_q;
  logic                 os_prev_q;
  logic                 os_tick;
  logic                 rx_s;

  state_e               state_q;
  logic [TW-1:0]        tick_q;
  logic [TW-1:0]        tick_inc;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 rx_frame_err_q;

  // Two-flop synchronizers; both idle high so reset looks like an idle line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os_sync_q <= 2'b11;
      rx_sync_q <= 2'b11;
      os_prev_q <= 1'b1;
    end else begin
      os_sync_q <= {os_sync_q[0], os_clk};
      rx_sync_q <= {rx_sync_q[0], rx};
      os_prev_q <= os_sync_q[1];
    end
  end

  assign os_tick  = os_sync_q[1] & ~os_prev_q;
  assign rx_s     = rx_sync_q[1];
  assign tick_inc = tick_q + 1'b1;

  // Frame FSM with registered strobes and byte output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      tick_q         <= '0;
      bit_q          <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
    end else begin
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (os_tick && !rx_s) begin
            state_q <= StStart;
            tick_q  <= '0;
          end
        end
        StStart: begin
          // The entry tick counts as 0, so the mid-start check falls
          // OVERSAMPLE/2-1 ticks after the low level was first seen.
          if (os_tick) begin
            if (tick_inc == TickMid) begin
              state_q <= rx_s ? StIdle : StData;
              tick_q  <= '0;
              bit_q   <= '0;
            end else begin
              tick_q <= tick_inc;
            end
          end
        end
        StData: begin
          if (os_tick) begin
            if (tick_q == TickLast) begin
              shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
              tick_q  <= '0;
              bit_q   <= bit_q + 1'b1;
              if (bit_q == BitLast) begin
                state_q <= StStop;
              end
            end else begin
              tick_q <= tick_inc;
            end
          end
        end
        StStop: begin
          if (os_tick) begin
            if (tick_q == TickLast) begin
              tick_q <= '0;
              if (rx_s) begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
                state_q    <= StIdle;
              end else begin
                rx_frame_err_q <= 1'b1;
                state_q        <= StBreak;
              end
            end else begin
              tick_q <= tick_inc;
            end
          end
        end
        StBreak: begin
          // Hold off until the line returns high so a stuck-low line is one error.
          if (os_tick && rx_s) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_frame_err_q;
  assign rx_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: a table of frames, hand-written corner sequences, and
// random frames, all compared against an event-level model of the receiver.
`timescale 1ns/1ps

module tb_uart_rx_os16;

  // Divider runs faster than the board rate to keep the run short; ratios hold.
  localparam int OsHalf  = 6;
  localparam int BitClks = 2 * OsHalf * 16;
  localparam int BitLo   = 186;
  localparam int BitHi   = 198;
  localparam int Glitch  = 43;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       os_clk = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  uart_rx_os16 #(
    .DATA_BITS (8),
    .OVERSAMPLE(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .os_clk      (os_clk),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3;
    forever #(OsHalf * 10) os_clk = ~os_clk;
  end

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         bit_clks;
    int         hold_bits;
    int         gap_clks;
    logic       exp_err;
    logic [7:0] exp_data;
  } vec_t;

  int         tests = 0;
  int         fails = 0;
  ev_t        exp_q[$];
  ev_t        obs_q[$];
  logic [7:0] last_good = 8'h00;
  int         busy_cd = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Record every strobe the DUT emits; rx_data alongside an error strobe is the held byte.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid || rx_frame_err) begin
        check("valid_err_exclusive", {31'b0, rx_valid & rx_frame_err}, 32'd0);
        obs_q.push_back('{is_err: rx_frame_err, data: rx_data});
      end
      if (rx_valid) begin
        busy_cd = 2;
      end else if (busy_cd > 0) begin
        busy_cd--;
        if (busy_cd == 0) check("busy_after_valid", {31'b0, rx_busy}, 32'd0);
      end
    end else begin
      busy_cd = 0;
    end
  end

  // Reference behaviour: good stop bit yields the byte, bad stop bit yields one
  // error strobe with the last good byte still on rx_data.
  task automatic model_frame(input logic [7:0] d, input bit stop_ok);
    if (stop_ok) begin
      exp_q.push_back('{is_err: 1'b0, data: d});
      last_good = d;
    end else begin
      exp_q.push_back('{is_err: 1'b1, data: last_good});
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int bclks,
                            input int hold_bits);
    rx = 1'b0;
    #(bclks * 10);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(bclks * 10);
    end
    rx = stop_ok;
    #(bclks * 10);
    if (!stop_ok) #(hold_bits * bclks * 10);
    rx = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    check({name, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_kind%0d", name, i), {31'b0, obs_q[i].is_err}, {31'b0, exp_q[i].is_err});
      check($sformatf("%s_data%0d", name, i), {24'b0, obs_q[i].data}, {24'b0, exp_q[i].data});
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    vec_t       vecs[8];
    logic [7:0] d;
    bit         ok;
    int         bt;
    int         gap;

    vecs[0] = '{8'hA5, 1'b1, BitClks, 0, 600, 1'b0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, BitClks, 0, 0,   1'b0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, BitClks, 0, 0,   1'b0, 8'hFF};
    vecs[3] = '{8'h3C, 1'b1, BitClks, 0, 600, 1'b0, 8'h3C};
    vecs[4] = '{8'h96, 1'b1, BitLo,   0, 600, 1'b0, 8'h96};
    vecs[5] = '{8'h96, 1'b1, BitHi,   0, 600, 1'b0, 8'h96};
    vecs[6] = '{8'h55, 1'b0, BitClks, 3, 600, 1'b1, 8'h96};
    vecs[7] = '{8'h81, 1'b1, BitClks, 0, 600, 1'b0, 8'h81};

    // Reset state
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset_rx_data", {24'b0, rx_data}, 32'd0);
    check("reset_rx_valid", {31'b0, rx_valid}, 32'd0);
    check("reset_rx_frame_err", {31'b0, rx_frame_err}, 32'd0);
    check("reset_rx_busy", {31'b0, rx_busy}, 32'd0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);

    // Table-driven frames
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back('{is_err: vecs[i].exp_err, data: vecs[i].exp_data});
      if (!vecs[i].exp_err) last_good = vecs[i].exp_data;
      send_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].bit_clks, vecs[i].hold_bits);
      if (vecs[i].gap_clks > 0) begin
        #(vecs[i].gap_clks * 10);
        drain($sformatf("vec%0d", i));
      end
    end

    // False start: short low glitch must not start a frame
    rx = 1'b0;
    #(Glitch * 10);
    rx = 1'b1;
    #(BitClks * 10);
    check("false_start_busy", {31'b0, rx_busy}, 32'd0);
    drain("false_start");

    // Reset during data bit 4 of 0xC3 aborts the frame
    d = 8'hC3;
    rx = 1'b0;
    #(BitClks * 10);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      #(BitClks * 10);
    end
    rx = d[4];
    #((BitClks / 2) * 10);
    rst_n = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    check("midreset_rx_data", {24'b0, rx_data}, 32'd0);
    check("midreset_rx_valid", {31'b0, rx_valid}, 32'd0);
    check("midreset_rx_frame_err", {31'b0, rx_frame_err}, 32'd0);
    check("midreset_rx_busy", {31'b0, rx_busy}, 32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete();
    exp_q.delete();
    last_good = 8'h00;
    #(2 * BitClks * 10);
    model_frame(8'h7E, 1'b1);
    send_frame(8'h7E, 1'b1, BitClks, 0);
    #(600 * 10);
    drain("reset_recover");

    // Random frames with skewed baud, random gaps and occasional bad stop bits
    for (int i = 0; i < 12; i++) begin
      d   = 8'($urandom);
      ok  = ($urandom_range(0, 3) != 0);
      bt  = $urandom_range(BitLo, BitHi);
      gap = ok ? (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(100, 800))
               : $urandom_range(300, 800);
      model_frame(d, ok);
      send_frame(d, ok, bt, $urandom_range(0, 2));
      if (gap > 0) begin
        #(gap * 10);
        drain($sformatf("rand%0d", i));
      end
    end
    #(600 * 10);
    drain("rand_tail");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #950_000;
    fails++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
